// File: rtl/alu_arbiter_if.sv
// Request/response bus between two requesters and the shared ALU arbiter.
interface alu_arbiter_if;
  logic        req_valid_0;
  logic        req_valid_1;
  logic        req_ready_0;
  logic        req_ready_1;
  logic [3:0]  req_op_0;
  logic [3:0]  req_op_1;
  logic [31:0] req_a_0;
  logic [31:0] req_a_1;
  logic [31:0] req_b_0;
  logic [31:0] req_b_1;
  logic        rsp_valid_0;
  logic        rsp_valid_1;
  logic [31:0] rsp_data_0;
  logic [31:0] rsp_data_1;
  logic        rsp_err_0;
  logic        rsp_err_1;
  logic        rsp_ready_0;
  logic        rsp_ready_1;

  // Requester side: issues operations and consumes responses.
  modport master (
    output req_valid_0, req_valid_1,
    output req_op_0, req_op_1,
    output req_a_0, req_a_1,
    output req_b_0, req_b_1,
    output rsp_ready_0, rsp_ready_1,
    input  req_ready_0, req_ready_1,
    input  rsp_valid_0, rsp_valid_1,
    input  rsp_data_0, rsp_data_1,
    input  rsp_err_0, rsp_err_1
  );

  // Arbiter side.
  modport slave (
    input  req_valid_0, req_valid_1,
    input  req_op_0, req_op_1,
    input  req_a_0, req_a_1,
    input  req_b_0, req_b_1,
    input  rsp_ready_0, rsp_ready_1,
    output req_ready_0, req_ready_1,
    output rsp_valid_0, rsp_valid_1,
    output rsp_data_0, rsp_data_1,
    output rsp_err_0, rsp_err_1
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Accepted requests pass through a one-entry operand stage; each result lands
// in a per-requester holding register until the requester consumes it.
module alu_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned SH_W  = 5;
  localparam int unsigned N_REQ = 2;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            id;
  } stage_t;

  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] rsp_ready;
  stage_t           req_pl [N_REQ];

  logic [N_REQ-1:0] inflight_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [N_REQ-1:0] rsp_err_q;
  logic [XLEN-1:0]  rsp_data_q [N_REQ];
  logic             last_grant_q;
  logic             stage_valid_q;
  stage_t           stage_q;

  logic [N_REQ-1:0] busy;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] consume;
  logic             accept;
  logic             accept_id;

  logic [OP_W-1:0]  alu_op;
  logic [XLEN-1:0]  operand_a;
  logic [XLEN-1:0]  operand_b;
  logic [XLEN-1:0]  alu_data;
  logic             alu_illegal;
  logic [SH_W-1:0]  shamt;

  // Flatten the interface into per-requester vectors.
  assign req_valid = {bus.req_valid_1, bus.req_valid_0};
  assign rsp_ready = {bus.rsp_ready_1, bus.rsp_ready_0};
  assign req_pl[0] = '{op: bus.req_op_0, a: bus.req_a_0, b: bus.req_b_0, id: 1'b0};
  assign req_pl[1] = '{op: bus.req_op_1, a: bus.req_a_1, b: bus.req_b_1, id: 1'b1};

  assign busy    = inflight_q | rsp_valid_q;
  assign consume = rsp_valid_q & rsp_ready;

  // Round-robin grant: on a tie the requester not granted last time wins.
  always_comb begin
    elig  = req_valid & ~busy & {N_REQ{~rst}};
    grant = '0;
    if (elig == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end else begin
      grant = elig;
    end
  end

  assign accept    = |grant;
  assign accept_id = grant[1];

  // Operand stage drives the ALU.
  assign alu_op    = stage_q.op;
  assign operand_a = stage_q.a;
  assign operand_b = stage_q.b;
  assign shamt     = operand_b[SH_W-1:0];

  // Combinational ALU; unsupported encodings yield zero and flag illegal.
  always_comb begin
    alu_data    = '0;
    alu_illegal = 1'b0;
    unique case (alu_op)
      4'h0: alu_data = operand_a + operand_b;
      4'h8: alu_data = operand_a - operand_b;
      4'h2: alu_data = XLEN'($signed(operand_a) < $signed(operand_b));
      4'h3: alu_data = XLEN'(operand_a < operand_b);
      4'h4: alu_data = operand_a ^ operand_b;
      4'h6: alu_data = operand_a | operand_b;
      4'h7: alu_data = operand_a & operand_b;
      4'h1: alu_data = operand_a << shamt;
      4'h5: alu_data = operand_a >> shamt;
      4'hd: alu_data = XLEN'($signed(operand_a) >>> shamt);
      4'hb: alu_data = operand_b;
      default: begin
        alu_data    = '0;
        alu_illegal = 1'b1;
      end
    endcase
  end

  // Stage register and round-robin pointer, loaded on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_q <= 1'b0;
      stage_q       <= '0;
      last_grant_q  <= 1'b1;
    end else begin
      stage_valid_q <= accept;
      if (accept) begin
        stage_q      <= req_pl[accept_id];
        last_grant_q <= accept_id;
      end
    end
  end

  // Per-requester in-flight tracking and response holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q  <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        rsp_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (consume[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
        if (stage_valid_q && (stage_q.id == 1'(i))) begin
          rsp_data_q[i]  <= alu_illegal ? '0 : alu_data;
          rsp_err_q[i]   <= alu_illegal;
          rsp_valid_q[i] <= 1'b1;
          inflight_q[i]  <= 1'b0;
        end
        if (grant[i]) begin
          inflight_q[i] <= 1'b1;
        end
      end
    end
  end

  // Completed-operation counter; both requesters may consume on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else begin
      op_count <= op_count + CNT_W'(consume[0]) + CNT_W'(consume[1]);
    end
  end

  assign bus.req_ready_0 = grant[0];
  assign bus.req_ready_1 = grant[1];
  assign bus.rsp_valid_0 = rsp_valid_q[0];
  assign bus.rsp_valid_1 = rsp_valid_q[1];
  assign bus.rsp_data_0  = rsp_data_q[0];
  assign bus.rsp_data_1  = rsp_data_q[1];
  assign bus.rsp_err_0   = rsp_err_q[0];
  assign bus.rsp_err_1   = rsp_err_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter, counter width 4 so wrap is reachable.
module tb_alu_arbiter;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] op_count;
  int               errors;
  int               checks;
  int               exp_cnt;

  alu_arbiter_if bus ();

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk(tag, 32'(op_count), 32'(exp_cnt % 16));
  endtask

  // One complete request/response round trip on requester 0.
  task automatic run_op0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic exp_e, input string tag);
    bus.req_op_0    = op;
    bus.req_a_0     = a;
    bus.req_b_0     = b;
    bus.req_valid_0 = 1'b1;
    #1;
    chk({tag, "_ready"}, 32'(bus.req_ready_0), 32'd1);
    tick;
    bus.req_valid_0 = 1'b0;
    #1;
    chk({tag, "_lat"}, 32'(bus.rsp_valid_0), 32'd0);
    tick;
    chk({tag, "_valid"}, 32'(bus.rsp_valid_0), 32'd1);
    chk({tag, "_data"}, bus.rsp_data_0, exp_d);
    chk({tag, "_err"}, 32'(bus.rsp_err_0), 32'(exp_e));
    bus.rsp_ready_0 = 1'b1;
    tick;
    bus.rsp_ready_0 = 1'b0;
    exp_cnt++;
    chk({tag, "_consumed"}, 32'(bus.rsp_valid_0), 32'd0);
    chk_cnt({tag, "_cnt"});
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    exp_cnt = 0;
    rst = 1'b1;
    bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
    bus.req_op_0 = '0; bus.req_op_1 = '0;
    bus.req_a_0 = '0; bus.req_a_1 = '0;
    bus.req_b_0 = '0; bus.req_b_1 = '0;
    bus.rsp_ready_0 = 1'b0; bus.rsp_ready_1 = 1'b0;
    tick;
    tick;

    // Reset state, and ready suppressed while rst is high
    bus.req_valid_0 = 1'b1;
    bus.req_valid_1 = 1'b1;
    #1;
    chk("rst_ready0", 32'(bus.req_ready_0), 32'd0);
    chk("rst_ready1", 32'(bus.req_ready_1), 32'd0);
    chk("rst_valid0", 32'(bus.rsp_valid_0), 32'd0);
    chk("rst_valid1", 32'(bus.rsp_valid_1), 32'd0);
    chk("rst_data0", bus.rsp_data_0, 32'd0);
    chk("rst_err0", 32'(bus.rsp_err_0), 32'd0);
    chk_cnt("rst_cnt");
    bus.req_valid_0 = 1'b0;
    bus.req_valid_1 = 1'b0;
    rst = 1'b0;
    tick;

    // Single add
    run_op0(4'h0, 32'd5, 32'd3, 32'd8, 1'b0, "add");

    // Fresh reset, then first-tie arbitration
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_cnt = 0;
    chk_cnt("rst2_cnt");
    bus.req_op_0 = 4'h8; bus.req_a_0 = 32'd10; bus.req_b_0 = 32'd3; bus.req_valid_0 = 1'b1;
    bus.req_op_1 = 4'h1; bus.req_a_1 = 32'd1;  bus.req_b_1 = 32'd4; bus.req_valid_1 = 1'b1;
    #1;
    chk("tie_ready0", 32'(bus.req_ready_0), 32'd1);
    chk("tie_ready1", 32'(bus.req_ready_1), 32'd0);
    tick;
    bus.req_valid_0 = 1'b0;
    #1;
    chk("tie_ready1_next", 32'(bus.req_ready_1), 32'd1);
    chk("tie_ready0_busy", 32'(bus.req_ready_0), 32'd0);
    tick;
    bus.req_valid_1 = 1'b0;
    #1;
    chk("tie_valid0", 32'(bus.rsp_valid_0), 32'd1);
    chk("tie_data0", bus.rsp_data_0, 32'd7);
    chk("tie_valid1_early", 32'(bus.rsp_valid_1), 32'd0);
    tick;
    chk("tie_valid1", 32'(bus.rsp_valid_1), 32'd1);
    chk("tie_data1", bus.rsp_data_1, 32'h10);
    chk("tie_data0_hold", bus.rsp_data_0, 32'd7);
    bus.rsp_ready_0 = 1'b1;
    bus.rsp_ready_1 = 1'b1;
    tick;
    bus.rsp_ready_0 = 1'b0;
    bus.rsp_ready_1 = 1'b0;
    exp_cnt += 2;
    chk_cnt("tie_cnt_dual");
    chk("tie_valid0_clr", 32'(bus.rsp_valid_0), 32'd0);
    chk("tie_valid1_clr", 32'(bus.rsp_valid_1), 32'd0);

    // Round-robin with last grant = requester 1
    bus.req_op_0 = 4'h0; bus.req_a_0 = 32'd1; bus.req_b_0 = 32'd1; bus.req_valid_0 = 1'b1;
    bus.req_op_1 = 4'h0; bus.req_a_1 = 32'd2; bus.req_b_1 = 32'd2; bus.req_valid_1 = 1'b1;
    #1;
    chk("rr1_ready0", 32'(bus.req_ready_0), 32'd1);
    chk("rr1_ready1", 32'(bus.req_ready_1), 32'd0);
    tick;
    bus.req_valid_0 = 1'b0;
    #1;
    chk("rr1_ready1_next", 32'(bus.req_ready_1), 32'd1);
    tick;
    bus.req_valid_1 = 1'b0;
    #1;
    chk("rr1_data0", bus.rsp_data_0, 32'd2);
    tick;
    chk("rr1_data1", bus.rsp_data_1, 32'd4);
    bus.rsp_ready_0 = 1'b1;
    bus.rsp_ready_1 = 1'b1;
    tick;
    bus.rsp_ready_0 = 1'b0;
    bus.rsp_ready_1 = 1'b0;
    exp_cnt += 2;
    chk_cnt("rr1_cnt");

    // Solo grant to requester 0, then tie goes to requester 1
    run_op0(4'h4, 32'hF0, 32'hFF, 32'h0F, 1'b0, "xor");
    bus.req_op_0 = 4'h7; bus.req_a_0 = 32'hFF; bus.req_b_0 = 32'h0F; bus.req_valid_0 = 1'b1;
    bus.req_op_1 = 4'h6; bus.req_a_1 = 32'h10; bus.req_b_1 = 32'h01; bus.req_valid_1 = 1'b1;
    #1;
    chk("rr0_ready1", 32'(bus.req_ready_1), 32'd1);
    chk("rr0_ready0", 32'(bus.req_ready_0), 32'd0);
    tick;
    bus.req_valid_1 = 1'b0;
    #1;
    chk("rr0_ready0_next", 32'(bus.req_ready_0), 32'd1);
    tick;
    bus.req_valid_0 = 1'b0;
    #1;
    chk("rr0_valid1", 32'(bus.rsp_valid_1), 32'd1);
    chk("rr0_data1", bus.rsp_data_1, 32'h11);
    tick;
    chk("rr0_valid0", 32'(bus.rsp_valid_0), 32'd1);
    chk("rr0_data0", bus.rsp_data_0, 32'h0F);
    bus.rsp_ready_0 = 1'b1;
    bus.rsp_ready_1 = 1'b1;
    tick;
    bus.rsp_ready_0 = 1'b0;
    bus.rsp_ready_1 = 1'b0;
    exp_cnt += 2;
    chk_cnt("rr0_cnt");

    // Backpressure on requester 0 while requester 1 is served
    bus.req_op_0 = 4'h5; bus.req_a_0 = 32'h80; bus.req_b_0 = 32'd3; bus.req_valid_0 = 1'b1;
    #1;
    tick;
    bus.req_valid_0 = 1'b0;
    tick;
    chk("bp_valid0", 32'(bus.rsp_valid_0), 32'd1);
    chk("bp_data0", bus.rsp_data_0, 32'h10);
    bus.req_op_0 = 4'h0; bus.req_valid_0 = 1'b1;
    bus.req_op_1 = 4'h2; bus.req_a_1 = 32'hFFFF_FFFF; bus.req_b_1 = 32'd1; bus.req_valid_1 = 1'b1;
    #1;
    chk("bp_ready1", 32'(bus.req_ready_1), 32'd1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready0_low", 32'(bus.req_ready_0), 32'd0);
      chk("bp_data0_stable", bus.rsp_data_0, 32'h10);
      chk("bp_valid0_held", 32'(bus.rsp_valid_0), 32'd1);
      tick;
      if (i == 0) bus.req_valid_1 = 1'b0;
    end
    chk("bp_valid1", 32'(bus.rsp_valid_1), 32'd1);
    chk("bp_slt", bus.rsp_data_1, 32'd1);
    bus.req_valid_0 = 1'b0;
    bus.rsp_ready_0 = 1'b1;
    bus.rsp_ready_1 = 1'b1;
    tick;
    bus.rsp_ready_0 = 1'b0;
    bus.rsp_ready_1 = 1'b0;
    exp_cnt += 2;
    chk_cnt("bp_cnt");

    // Illegal and signed ops
    run_op0(4'he, 32'd1, 32'd2, 32'd0, 1'b1, "illegal");
    run_op0(4'hd, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, "sra");
    run_op0(4'h3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, "sltu");
    run_op0(4'hb, 32'h1234, 32'hABCD_0000, 32'hABCD_0000, 1'b0, "lui");

    // Reset mid-operation discards the request
    bus.req_op_0 = 4'h0; bus.req_a_0 = 32'd1; bus.req_b_0 = 32'd1; bus.req_valid_0 = 1'b1;
    #1;
    chk("rstmid_ready0", 32'(bus.req_ready_0), 32'd1);
    tick;
    bus.req_valid_0 = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_cnt = 0;
    chk_cnt("rstmid_cnt");
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_valid0", 32'(bus.rsp_valid_0), 32'd0);
      chk("rstmid_valid1", 32'(bus.rsp_valid_1), 32'd0);
      tick;
    end
    chk("rstmid_data0", bus.rsp_data_0, 32'd0);

    // Counter wrap after 16 consumed ops
    for (int i = 0; i < 16; i++) begin
      run_op0(4'hb, 32'd0, 32'(i + 1), 32'(i + 1), 1'b0, "wrap");
    end
    chk("wrap_zero", 32'(op_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters, such as the integer pipeline and a future multi-cycle/CSR unit, using a valid/ready request and response handshake. Requests are granted round-robin and registered into the ALU operand stage. Each result is registered into a per-requester response holding register. The block also flags unsupported `alu_op` encodings and counts completed operations.

## Interface
- `CNT_W`, default 16: width of the completed-operation counter.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid_0` / `req_valid_1`  in  1  request present.
- `req_ready_0` / `req_ready_1`  out  1  request accepted this cycle when high together with valid.
- `req_op_0` / `req_op_1`  in  4  ALU operation, same encoding as `alu_op`.
- `req_a_0` / `req_a_1`  in  32  operand_a.
- `req_b_0` / `req_b_1`  in  32  operand_b.
- `rsp_valid_0` / `rsp_valid_1`  out  1  result held for requester.
- `rsp_data_0` / `rsp_data_1`  out  32  result.
- `rsp_err_0` / `rsp_err_1`  out  1  op was an unsupported encoding.
- `rsp_ready_0` / `rsp_ready_1`  in  1  requester consumes the response.
- `op_count`  out  CNT_W  number of responses consumed; wraps modulo 2^CNT_W.

## Operation
- Legal ops: 0 add, 8 sub, 2 slt, 3 sltu, 4 xor, 6 or, 7 and, 1 sll, 5 srl, d sra, b lui (result = b). Illegal ops: 9, a, c, e, f.
- Per-requester state: `inflight_N` (accepted, result not yet registered) and `rsp_valid_N`. `busy_N = inflight_N | rsp_valid_N`.
- Eligibility: `elig_N = req_valid_N & ~busy_N & ~rst`.
- Grant is combinational and one-hot, with at most one grant per cycle:
  - Only one requester eligible: that requester wins.
  - Both eligible: the requester not named by `last_grant` wins.
  - `req_ready_N = grant_N`. It is never high while `busy_N` or `rst` is high.
- Accept (`req_valid_N & req_ready_N` at an edge):
  - Latch op, a, b and requester id into the stage register; set `stage_valid` and `inflight_N`.
  - Set `last_grant` to N.
- Stage cycle: the stage register drives `alu_op`, `operand_a` and `operand_b`. At the next edge:
  - Write `rsp_data_N` = `alu_data`, or 0 if the op is illegal.
  - Write `rsp_err_N` = illegal.
  - Set `rsp_valid_N`, clear `inflight_N`, clear `stage_valid` unless a new accept occurs at the same edge.
- Response consume (`rsp_valid_N & rsp_ready_N` at an edge): clear `rsp_valid_N` and increment `op_count`. Data and err may keep their old values.
- `rsp_data_N` and `rsp_err_N` are stable for as long as `rsp_valid_N` is high.
- Simultaneous events on the same edge must all be honoured:
  - A stage write for requester X and an accept of requester Y≠X.
  - A consume by one requester and a stage write for the other.
  - Both requesters consuming at once: `op_count` increments by 2.
- A requester cannot issue a new request in the same cycle its own response is consumed. Minimum per-requester issue interval is 3 cycles.

## Timing
- Accept at end of cycle n. ALU evaluates in cycle n+1. `rsp_valid_N` is high from cycle n+2. Latency 2.
- Aggregate throughput: one accept per cycle. With both requesters active, grants alternate.
- Reset values, forced while `rst` is high and valid after the first edge with `rst` high:
  - `req_ready_*` = 0, `rsp_valid_*` = 0, `rsp_data_*` = 0, `rsp_err_*` = 0, `op_count` = 0.
  - `stage_valid` = 0, `inflight_*` = 0, `last_grant` = 1, so requester 0 wins the first tie.
- Reset mid-operation discards the stage and all held responses. No response for a discarded request ever appears.
- `rsp_valid` never depends combinationally on `rsp_ready`. `req_ready` depends combinationally on `req_valid_*` and registered state only.

## Test plan
- **Single add:** req0 op 0, a=5, b=3 accepted in cycle n → `rsp_valid_0`=1 in cycle n+2, data 8, err 0. After `rsp_ready_0`, `op_count`=1.
- **First-tie arbitration:** right after reset, both requesters assert in cycle n: req0 sub 10−3, req1 sll 1<<4.
  - `req_ready_0` high in cycle n, `req_ready_1` high in cycle n+1.
  - Responses 7 (cycle n+2) and 0x10 (cycle n+3).
- **Round-robin after a grant:** both requesters become eligible again with `last_grant`=1 → req0 granted first. With `last_grant`=0 → req1 granted first.
- **Backpressure:** hold `rsp_ready_0` low for 5 cycles with a pending response.
  - `rsp_data_0` stays stable and `req_ready_0` stays 0.
  - req1 slt a=0xFFFFFFFF, b=1 is still served with result 1.
- **Illegal op and signed ops:**
  - req0 op e → data 0, err 1.
  - op d, a=0x80000000, b=4 → 0xF8000000.
  - op 3, a=0xFFFFFFFF, b=1 → 0.
- **Reset and counter wrap:**
  - `rst` pulsed in cycle n+1 after an accept → no `rsp_valid` ever appears, `op_count`=0.
  - With `CNT_W`=4, 16 consumed ops → `op_count` wraps to 0.
